// File: rtl/object_square_anim_if.sv
// Pixel-side bundle between the sync/counter generator, the square object and the colour mux.
interface object_square_anim_if;
  logic [9:0] HCount;
  logic [9:0] VCount;
  logic       square_select;
  logic       full_screen;
  logic [1:0] mode;
  logic [9:0] pos_x_in;
  logic [9:0] pos_y_in;
  logic       pos_load;
  logic       square_on;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       frame_tick;

  modport master (
    output HCount, VCount, square_select, full_screen, mode, pos_x_in, pos_y_in, pos_load,
    input  square_on, pos_x, pos_y, frame_tick
  );

  modport slave (
    input  HCount, VCount, square_select, full_screen, mode, pos_x_in, pos_y_in, pos_load,
    output square_on, pos_x, pos_y, frame_tick
  );
endinterface

// File: rtl/object_square_anim.sv
// Registered square-object generator with a movable position, per-frame bounce motion
// and frame-counted blinking; one clk of latency from HCount/VCount to square_on.
module object_square_anim #(
  parameter int unsigned SIZE         = 40,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned STEP         = 2,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned INIT_X       = 280,
  parameter int unsigned INIT_Y       = 60
) (
  input logic                 clk,
  input logic                 rst_n,
  object_square_anim_if.slave bus
);

  localparam int unsigned CNT_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [9:0]  X_MAX      = 10'(H_ACTIVE - SIZE);
  localparam logic [9:0]  Y_MAX      = 10'(V_ACTIVE - SIZE);
  localparam logic [9:0]  INIT_X_W   = 10'(INIT_X);
  localparam logic [9:0]  INIT_Y_W   = 10'(INIT_Y);
  localparam logic [10:0] SIZE_W     = 11'(SIZE);
  localparam logic [10:0] STEP_W     = 11'(STEP);
  localparam logic [10:0] H_ACT_W    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_W    = 11'(V_ACTIVE);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

  // Returns {dir_neg_next, pos_next} for one bounce step along an axis limited to [0, lim].
  function automatic logic [10:0] bounce_axis(input logic [9:0] pos, input logic dir_neg,
                                              input logic [9:0] lim);
    logic [10:0] res;
    res = {dir_neg, pos};
    if (!dir_neg) begin
      if (({1'b0, pos} + STEP_W) > {1'b0, lim}) begin
        res = {1'b1, lim};
      end else begin
        res = {1'b0, pos + STEP_W[9:0]};
      end
    end else begin
      if ({1'b0, pos} < STEP_W) begin
        res = {1'b0, 10'd0};
      end else begin
        res = {1'b1, pos - STEP_W[9:0]};
      end
    end
    return res;
  endfunction

  function automatic logic [9:0] clamp_pos(input logic [9:0] value, input logic [9:0] lim);
    logic [9:0] res;
    if (value > lim) begin
      res = lim;
    end else begin
      res = value;
    end
    return res;
  endfunction

  logic [9:0]       pos_x_r, pos_y_r;
  logic             dir_x_r, dir_y_r;   // 1 = moving towards 0
  logic [CNT_W-1:0] blink_cnt_r;
  logic             visible_r;
  logic             cond_d_r;
  logic             square_on_r;
  logic             frame_tick_r;

  logic [10:0] h_s, v_s, px_s, py_s;
  logic        hit_s, active_s, area_s, cond_s, tick_s, on_next_s;
  logic [10:0] bounce_x_s, bounce_y_s;

  // Pixel hit test, active-area test and end-of-frame edge detection, all in 11 bits.
  always_comb begin
    h_s        = {1'b0, bus.HCount};
    v_s        = {1'b0, bus.VCount};
    px_s       = {1'b0, pos_x_r};
    py_s       = {1'b0, pos_y_r};
    hit_s      = (h_s >= px_s) && (h_s <= (px_s + SIZE_W - 11'd1)) &&
                 (v_s >= py_s) && (v_s <= (py_s + SIZE_W - 11'd1));
    active_s   = (h_s < H_ACT_W) && (v_s < V_ACT_W);
    cond_s     = (v_s == V_ACT_W) && (h_s == 11'd0);
    tick_s     = cond_s && !cond_d_r;
    if (bus.full_screen) begin
      area_s = active_s;
    end else begin
      area_s = hit_s;
    end
    on_next_s  = bus.square_select && visible_r && area_s;
    bounce_x_s = bounce_axis(pos_x_r, dir_x_r, X_MAX);
    bounce_y_s = bounce_axis(pos_y_r, dir_y_r, Y_MAX);
  end

  // Output, position, direction and blink state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x_r      <= INIT_X_W;
      pos_y_r      <= INIT_Y_W;
      dir_x_r      <= 1'b0;
      dir_y_r      <= 1'b0;
      blink_cnt_r  <= '0;
      visible_r    <= 1'b1;
      cond_d_r     <= 1'b0;
      square_on_r  <= 1'b0;
      frame_tick_r <= 1'b0;
    end else begin
      square_on_r  <= on_next_s;
      frame_tick_r <= tick_s;
      cond_d_r     <= cond_s;

      // A load always beats motion on the same clk.
      if (bus.pos_load) begin
        pos_x_r <= clamp_pos(bus.pos_x_in, X_MAX);
        pos_y_r <= clamp_pos(bus.pos_y_in, Y_MAX);
        dir_x_r <= 1'b0;
        dir_y_r <= 1'b0;
      end else if (tick_s && bus.mode[0]) begin
        {dir_x_r, pos_x_r} <= bounce_x_s;
        {dir_y_r, pos_y_r} <= bounce_y_s;
      end else begin
        pos_x_r <= pos_x_r;
        pos_y_r <= pos_y_r;
      end

      if (!bus.mode[1]) begin
        blink_cnt_r <= '0;
        visible_r   <= 1'b1;
      end else if (tick_s) begin
        if (blink_cnt_r == BLINK_LAST) begin
          blink_cnt_r <= '0;
          visible_r   <= ~visible_r;
        end else begin
          blink_cnt_r <= blink_cnt_r + CNT_W'(1);
        end
      end else begin
        blink_cnt_r <= blink_cnt_r;
      end
    end
  end

  assign bus.square_on  = square_on_r;
  assign bus.frame_tick = frame_tick_r;
  assign bus.pos_x      = pos_x_r;
  assign bus.pos_y      = pos_y_r;

endmodule

// File: tb/tb_object_square_anim.sv
// Randomised and directed checks of object_square_anim against a frame-level reference model.
module tb_object_square_anim;

  logic clk;
  logic rst_n;
  object_square_anim_if intf ();

  object_square_anim dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model state: positions as plain integers, directions as +1/-1.
  int m_x, m_y, m_dx, m_dy, m_cnt;
  bit m_vis, m_cond_prev, m_sq, m_tick;
  int mh, mv;
  bit m_active, m_hit, m_cond, m_now;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_x = 280; m_y = 60; m_dx = 1; m_dy = 1; m_cnt = 0;
      m_vis = 1'b1; m_cond_prev = 1'b0; m_sq = 1'b0; m_tick = 1'b0;
    end else begin
      mh       = int'(intf.HCount);
      mv       = int'(intf.VCount);
      m_active = (mh < 640) && (mv < 480);
      m_hit    = (mh >= m_x) && (mh < m_x + 40) && (mv >= m_y) && (mv < m_y + 40);
      m_cond   = (mv == 480) && (mh == 0);
      m_now    = m_cond && !m_cond_prev;
      m_sq     = intf.square_select && m_vis && (intf.full_screen ? m_active : m_hit);
      m_tick   = m_now;
      m_cond_prev = m_cond;
      if (intf.pos_load) begin
        m_x  = (int'(intf.pos_x_in) > 600) ? 600 : int'(intf.pos_x_in);
        m_y  = (int'(intf.pos_y_in) > 440) ? 440 : int'(intf.pos_y_in);
        m_dx = 1; m_dy = 1;
      end else if (m_now && intf.mode[0]) begin
        if (m_dx > 0) begin
          if (m_x + 2 > 600) begin m_x = 600; m_dx = -1; end else m_x = m_x + 2;
        end else begin
          if (m_x < 2) begin m_x = 0; m_dx = 1; end else m_x = m_x - 2;
        end
        if (m_dy > 0) begin
          if (m_y + 2 > 440) begin m_y = 440; m_dy = -1; end else m_y = m_y + 2;
        end else begin
          if (m_y < 2) begin m_y = 0; m_dy = 1; end else m_y = m_y - 2;
        end
      end
      if (!intf.mode[1]) begin
        m_cnt = 0; m_vis = 1'b1;
      end else if (m_now) begin
        if (m_cnt == 29) begin m_cnt = 0; m_vis = !m_vis; end else m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int hold);
    intf.VCount = 10'd480;
    intf.HCount = 10'd0;
    repeat (hold) step();
    intf.VCount = 10'd0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    intf.HCount = 10'd0; intf.VCount = 10'd0; intf.square_select = 1'b0;
    intf.full_screen = 1'b0; intf.mode = 2'd0; intf.pos_x_in = 10'd0;
    intf.pos_y_in = 10'd0; intf.pos_load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (intf.square_on !== 1'b0 || intf.frame_tick !== 1'b0 ||
        intf.pos_x !== 10'd280 || intf.pos_y !== 10'd60) begin
      n_err++;
      $display("FAIL reset: got on=%b tick=%b x=%0d y=%0d, want 0 0 280 60",
               intf.square_on, intf.frame_tick, intf.pos_x, intf.pos_y);
    end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_hit();
    logic [9:0] hs [4] = '{10'd280, 10'd320, 10'd319, 10'd279};
    logic [9:0] vs [4] = '{10'd60, 10'd60, 10'd99, 10'd99};
    logic       want [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    intf.mode = 2'd0; intf.square_select = 1'b1; intf.full_screen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      intf.HCount = hs[i]; intf.VCount = vs[i];
      step();
      n_vec++;
      if (intf.square_on !== want[i] || m_sq !== want[i]) begin
        n_err++;
        $display("FAIL hit[%0d]: H=%0d V=%0d got %b, want %b", i, hs[i], vs[i], intf.square_on, want[i]);
      end
    end
  endtask

  task automatic test_full_screen();
    logic [9:0] hs [4] = '{10'd280, 10'd280, 10'd700, 10'd639};
    logic       sel [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic       want [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    intf.full_screen = 1'b1; intf.VCount = 10'd185;
    for (int i = 0; i < 4; i++) begin
      intf.HCount = hs[i]; intf.square_select = sel[i];
      step();
      n_vec++;
      if (intf.square_on !== want[i]) begin
        n_err++;
        $display("FAIL full_screen[%0d]: got %b, want %b", i, intf.square_on, want[i]);
      end
    end
    intf.full_screen = 1'b0; intf.square_select = 1'b1;
  endtask

  task automatic test_bounce();
    intf.mode = 2'd1;
    intf.pos_x_in = 10'd596; intf.pos_y_in = 10'd100; intf.pos_load = 1'b1;
    step();
    intf.pos_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      frame(1);
      n_vec++;
      if (intf.pos_x !== m_x[9:0] || intf.pos_y !== m_y[9:0]) begin
        n_err++;
        $display("FAIL bounce[%0d]: got (%0d,%0d), want (%0d,%0d)", i, intf.pos_x, intf.pos_y, m_x, m_y);
      end
    end
  endtask

  task automatic test_clamp_and_priority();
    intf.pos_x_in = 10'd1000; intf.pos_y_in = 10'd470; intf.pos_load = 1'b1;
    step();
    intf.pos_load = 1'b0;
    n_vec++;
    if (intf.pos_x !== 10'd600 || intf.pos_y !== 10'd440) begin
      n_err++;
      $display("FAIL clamp: got (%0d,%0d), want (600,440)", intf.pos_x, intf.pos_y);
    end
    intf.mode = 2'd1;
    intf.pos_x_in = 10'd100; intf.pos_y_in = 10'd200; intf.pos_load = 1'b1;
    intf.VCount = 10'd480; intf.HCount = 10'd0;
    step();
    intf.pos_load = 1'b0;
    n_vec++;
    if (intf.pos_x !== 10'd100 || intf.pos_y !== 10'd200 || intf.frame_tick !== 1'b1) begin
      n_err++;
      $display("FAIL load_vs_tick: got (%0d,%0d) tick=%b, want (100,200) tick=1",
               intf.pos_x, intf.pos_y, intf.frame_tick);
    end
    intf.VCount = 10'd0;
    step();
  endtask

  task automatic test_frame_tick_hold();
    intf.VCount = 10'd480; intf.HCount = 10'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if (intf.frame_tick !== (i == 0)) begin
        n_err++;
        $display("FAIL tick_hold[%0d]: got %b, want %b", i, intf.frame_tick, (i == 0));
      end
    end
    intf.VCount = 10'd0;
    step();
  endtask

  task automatic test_blink();
    logic want [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int   nfr  [4] = '{29, 1, 30, 30};
    intf.mode = 2'd2; intf.square_select = 1'b1; intf.full_screen = 1'b0;
    intf.pos_x_in = 10'd280; intf.pos_y_in = 10'd60; intf.pos_load = 1'b1;
    step();
    intf.pos_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (nfr[i]) frame(1);
      intf.HCount = 10'd290; intf.VCount = 10'd70;
      step();
      n_vec++;
      if (intf.square_on !== want[i] || m_sq !== want[i]) begin
        n_err++;
        $display("FAIL blink[%0d]: got %b, want %b", i, intf.square_on, want[i]);
      end
    end
    intf.mode = 2'd0;
    step();
    step();
    n_vec++;
    if (intf.square_on !== 1'b1) begin
      n_err++;
      $display("FAIL blink_off: got %b, want 1", intf.square_on);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) intf.mode = 2'($urandom_range(0, 3));
      intf.square_select = ($urandom_range(0, 7) != 0);
      intf.full_screen   = ($urandom_range(0, 5) == 0);
      intf.pos_load      = ($urandom_range(0, 63) == 0);
      intf.pos_x_in      = 10'($urandom_range(0, 1023));
      intf.pos_y_in      = 10'($urandom_range(0, 1023));
      case ($urandom_range(0, 3))
        0: begin intf.VCount = 10'd480; intf.HCount = 10'd0; end
        1: begin
             intf.HCount = 10'(m_x + $urandom_range(0, 41) - 1);
             intf.VCount = 10'(m_y + $urandom_range(0, 41) - 1);
           end
        default: begin
             intf.HCount = 10'($urandom_range(0, 799));
             intf.VCount = 10'($urandom_range(0, 524));
           end
      endcase
      step();
      n_vec++;
      if (intf.square_on !== m_sq || intf.frame_tick !== m_tick ||
          intf.pos_x !== m_x[9:0] || intf.pos_y !== m_y[9:0]) begin
        n_err++;
        $display("FAIL random[%0d]: got on=%b tick=%b x=%0d y=%0d, want on=%b tick=%b x=%0d y=%0d",
                 i, intf.square_on, intf.frame_tick, intf.pos_x, intf.pos_y, m_sq, m_tick, m_x, m_y);
      end
    end
    intf.pos_load = 1'b0;
  endtask

  task automatic test_reset_mid();
    intf.mode = 2'd3; intf.square_select = 1'b1; intf.full_screen = 1'b0;
    repeat (7) frame(2);
    intf.HCount = 10'(m_x + 5); intf.VCount = 10'(m_y + 5);
    step();
    n_vec++;
    if (intf.square_on !== m_sq) begin
      n_err++;
      $display("FAIL pre_reset: got %b, want %b", intf.square_on, m_sq);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (intf.square_on !== 1'b0 || intf.pos_x !== 10'd280 || intf.pos_y !== 10'd60 ||
        intf.frame_tick !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: got on=%b x=%0d y=%0d tick=%b, want 0 280 60 0",
               intf.square_on, intf.pos_x, intf.pos_y, intf.frame_tick);
    end
    step();
    rst_n = 1'b1;
    intf.HCount = 10'd285; intf.VCount = 10'd65;
    step();
    n_vec++;
    if (intf.square_on !== 1'b1 || m_sq !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset: got %b, want 1", intf.square_on);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_hit();
    test_full_screen();
    test_bounce();
    test_clamp_and_priority();
    test_frame_tick_hold();
    test_blink();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
